// File: rtl/route_lookup_if.sv
// Signal bundle between the descriptor source, the router lookup block, the downstream consumer and route_lookup_ctrl.
interface route_lookup_if #(
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_dst_ip;
    logic [TAG_W-1:0] in_tag;
    logic             rt_init_done;
    logic             rt_init_error;
    logic             lookup_valid;
    logic [31:0]      lookup_dst_ip;
    logic             resp_valid;
    logic             resp_found;
    logic [15:0]      resp_out_port;
    logic [15:0]      resp_out_qp;
    logic [47:0]      resp_next_hop_mac;
    logic             resp_is_direct_host;
    logic             resp_is_broadcast;
    logic             resp_is_default_route;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      out_port;
    logic [15:0]      out_qp;
    logic [47:0]      out_mac;
    logic [2:0]       out_flags;
    logic             out_drop;
    logic [1:0]       out_reason;
    logic [15:0]      cnt_lookups;
    logic [15:0]      cnt_miss;
    logic [15:0]      cnt_timeout;

    modport master (
        output in_valid, in_dst_ip, in_tag, rt_init_done, rt_init_error,
               resp_valid, resp_found, resp_out_port, resp_out_qp, resp_next_hop_mac,
               resp_is_direct_host, resp_is_broadcast, resp_is_default_route, out_ready,
        input  in_ready, lookup_valid, lookup_dst_ip, out_valid, out_tag, out_port, out_qp,
               out_mac, out_flags, out_drop, out_reason, cnt_lookups, cnt_miss, cnt_timeout
    );

    modport slave (
        input  in_valid, in_dst_ip, in_tag, rt_init_done, rt_init_error,
               resp_valid, resp_found, resp_out_port, resp_out_qp, resp_next_hop_mac,
               resp_is_direct_host, resp_is_broadcast, resp_is_default_route, out_ready,
        output in_ready, lookup_valid, lookup_dst_ip, out_valid, out_tag, out_port, out_qp,
               out_mac, out_flags, out_drop, out_reason, cnt_lookups, cnt_miss, cnt_timeout
    );
endinterface

// File: rtl/route_lookup_ctrl.sv
// Buffers packet descriptors, issues one router lookup at a time with a response timeout,
// and presents a registered forwarding decision plus saturating statistics.
module route_lookup_ctrl #(
    parameter int unsigned TAG_W          = 8,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic           clk,
    input logic           rst_n,
    route_lookup_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned DW = 32 + TAG_W;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_OUTPUT,
        S_ERROR
    } state_t;

    state_t           state;
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             push_c;
    logic             pop_c;
    logic [DW-1:0]    head_c;
    logic [31:0]      cur_ip;
    logic [TAG_W-1:0] cur_tag;
    logic [TW-1:0]    timer;
    logic             from_err;
    logic             lookup_valid_r;
    logic             out_valid_r;
    logic [TAG_W-1:0] out_tag_r;
    logic [15:0]      out_port_r;
    logic [15:0]      out_qp_r;
    logic [47:0]      out_mac_r;
    logic [2:0]       out_flags_r;
    logic             out_drop_r;
    logic [1:0]       out_reason_r;
    logic [15:0]      cnt_lookups_r;
    logic [15:0]      cnt_miss_r;
    logic [15:0]      cnt_timeout_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty_c = (wr_ptr == rd_ptr);
    assign fifo_full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_c       = bus.in_valid && !fifo_full_c;
    assign pop_c        = !fifo_empty_c && ((state == S_IDLE) || (state == S_ERROR));
    assign head_c       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[AW-1:0]] <= {bus.in_tag, bus.in_dst_ip};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Control FSM with registered request, decision and statistics outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_WAIT_INIT;
            cur_ip         <= '0;
            cur_tag        <= '0;
            timer          <= '0;
            from_err       <= 1'b0;
            lookup_valid_r <= 1'b0;
            out_valid_r    <= 1'b0;
            out_tag_r      <= '0;
            out_port_r     <= '0;
            out_qp_r       <= '0;
            out_mac_r      <= '0;
            out_flags_r    <= '0;
            out_drop_r     <= 1'b0;
            out_reason_r   <= 2'b00;
            cnt_lookups_r  <= '0;
            cnt_miss_r     <= '0;
            cnt_timeout_r  <= '0;
        end else begin
            case (state)
                S_WAIT_INIT: begin
                    if (bus.rt_init_error)     state <= S_ERROR;
                    else if (bus.rt_init_done) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (pop_c) begin
                        cur_ip         <= head_c[31:0];
                        cur_tag        <= head_c[32 +: TAG_W];
                        lookup_valid_r <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lookup_valid_r <= 1'b0;
                    cnt_lookups_r  <= sat_inc(cnt_lookups_r);
                    timer          <= '0;
                    state          <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (bus.resp_valid) begin
                        out_valid_r  <= 1'b1;
                        out_tag_r    <= cur_tag;
                        out_port_r   <= bus.resp_out_port;
                        out_qp_r     <= bus.resp_out_qp;
                        out_mac_r    <= bus.resp_next_hop_mac;
                        out_flags_r  <= {bus.resp_is_default_route, bus.resp_is_broadcast,
                                         bus.resp_is_direct_host};
                        out_drop_r   <= !bus.resp_found;
                        out_reason_r <= bus.resp_found ? 2'b00 : 2'b01;
                        if (!bus.resp_found) cnt_miss_r <= sat_inc(cnt_miss_r);
                        from_err     <= 1'b0;
                        state        <= S_OUTPUT;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        out_valid_r   <= 1'b1;
                        out_tag_r     <= cur_tag;
                        out_port_r    <= '0;
                        out_qp_r      <= '0;
                        out_mac_r     <= '0;
                        out_flags_r   <= '0;
                        out_drop_r    <= 1'b1;
                        out_reason_r  <= 2'b10;
                        cnt_timeout_r <= sat_inc(cnt_timeout_r);
                        from_err      <= 1'b0;
                        state         <= S_OUTPUT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= from_err ? S_ERROR : S_IDLE;
                    end
                end
                S_ERROR: begin
                    // Flush queued descriptors as drops without touching the router.
                    if (pop_c) begin
                        out_valid_r  <= 1'b1;
                        out_tag_r    <= head_c[32 +: TAG_W];
                        out_port_r   <= '0;
                        out_qp_r     <= '0;
                        out_mac_r    <= '0;
                        out_flags_r  <= '0;
                        out_drop_r   <= 1'b1;
                        out_reason_r <= 2'b11;
                        from_err     <= 1'b1;
                        state        <= S_OUTPUT;
                    end
                end
                default: state <= S_WAIT_INIT;
            endcase
        end
    end

    assign bus.in_ready      = !fifo_full_c;
    assign bus.lookup_valid  = lookup_valid_r;
    assign bus.lookup_dst_ip = cur_ip;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_tag       = out_tag_r;
    assign bus.out_port      = out_port_r;
    assign bus.out_qp        = out_qp_r;
    assign bus.out_mac       = out_mac_r;
    assign bus.out_flags     = out_flags_r;
    assign bus.out_drop      = out_drop_r;
    assign bus.out_reason    = out_reason_r;
    assign bus.cnt_lookups   = cnt_lookups_r;
    assign bus.cnt_miss      = cnt_miss_r;
    assign bus.cnt_timeout   = cnt_timeout_r;
endmodule

// File: tb/tb_route_lookup_ctrl.sv
// Bench for route_lookup_ctrl: directed scenarios and randomized descriptors checked against
// a queue-based reference of expected lookups and decisions.
module tb_route_lookup_ctrl;
    localparam int unsigned TAG_W          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    typedef struct packed {
        logic [31:0]      ip;
        logic [TAG_W-1:0] tag;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          lv_count = 0;
    int          m_issued = 0;
    int          m_lookups = 0;
    int          m_miss = 0;
    int          m_timeout = 0;
    desc_t       model_q[$];
    logic [31:0] lk_q[$];
    desc_t       cur;

    route_lookup_if #(.TAG_W(TAG_W)) bus ();

    route_lookup_ctrl #(
        .TAG_W(TAG_W), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Records every lookup request pulse and the IP presented with it.
    always @(posedge clk) begin
        if (bus.lookup_valid) begin
            lv_count++;
            lk_q.push_back(bus.lookup_dst_ip);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [127:0] bundle(input logic [TAG_W-1:0] tag, input logic [15:0] port,
                                            input logic [15:0] qp, input logic [47:0] mac,
                                            input logic [2:0] flags, input logic drop,
                                            input logic [1:0] reason);
        return 128'({tag, port, qp, mac, flags, drop, reason});
    endfunction

    function automatic logic [127:0] out_bundle();
        return bundle(bus.out_tag, bus.out_port, bus.out_qp, bus.out_mac, bus.out_flags,
                      bus.out_drop, bus.out_reason);
    endfunction

    task automatic chk_counters();
        chk("cnt_lookups", 128'(bus.cnt_lookups), 128'(sat16(m_lookups)));
        chk("cnt_miss", 128'(bus.cnt_miss), 128'(sat16(m_miss)));
        chk("cnt_timeout", 128'(bus.cnt_timeout), 128'(sat16(m_timeout)));
        chk("lookup_pulses", 128'(lv_count), 128'(m_issued));
    endtask

    task automatic push(input logic [31:0] ip, input logic [TAG_W-1:0] tag);
        logic rdy;
        bus.in_valid  = 1'b1;
        bus.in_dst_ip = ip;
        bus.in_tag    = tag;
        rdy = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
        if (rdy) model_q.push_back('{ip: ip, tag: tag});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_ctrl", 128'({bus.lookup_valid, bus.out_valid, bus.in_ready}), 128'(3'b001));
        chk("rst_fields", out_bundle(), 128'(0));
        chk("rst_regs", 128'({bus.cnt_lookups, bus.cnt_miss, bus.cnt_timeout, bus.lookup_dst_ip}),
            128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        model_q.delete();
        lk_q.delete();
        m_issued = lv_count;
        m_lookups = 0;
        m_miss = 0;
        m_timeout = 0;
    endtask

    // Returns during the first response-wait cycle of the next lookup.
    task automatic wait_lookup(output bit ok);
        int n = 0;
        logic [31:0] ip;
        while (lv_count == m_issued && n < 200) begin
            tick();
            n++;
        end
        ok = (lv_count > m_issued) && (model_q.size() > 0) && (lk_q.size() > 0);
        chk("lookup_seen", 128'(ok), 128'(1));
        if (!ok) return;
        cur = model_q.pop_front();
        ip  = lk_q.pop_front();
        chk("lookup_ip", 128'(ip), 128'(cur.ip));
        m_issued++;
        m_lookups++;
    endtask

    task automatic hold_and_accept(input logic [127:0] exp, input int stall);
        repeat (stall) begin
            tick();
            chk("hold_valid", 128'(bus.out_valid), 128'(1));
            chk("hold_fields", out_bundle(), exp);
            chk("no_new_lookup", 128'(lv_count), 128'(m_issued));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_after_accept", 128'(bus.out_valid), 128'(0));
    endtask

    task automatic respond_check(input int delay, input logic found, input logic [15:0] port,
                                 input logic [15:0] qp, input logic [47:0] mac,
                                 input logic [2:0] flags, input int stall);
        logic [127:0] exp;
        repeat (delay) tick();
        chk("pre_resp_valid", 128'(bus.out_valid), 128'(0));
        bus.resp_valid            = 1'b1;
        bus.resp_found            = found;
        bus.resp_out_port         = port;
        bus.resp_out_qp           = qp;
        bus.resp_next_hop_mac     = mac;
        {bus.resp_is_default_route, bus.resp_is_broadcast, bus.resp_is_direct_host} = flags;
        tick();
        bus.resp_valid = 1'b0;
        chk("resp_latency", 128'(bus.out_valid), 128'(1));
        if (!found) m_miss++;
        exp = bundle(cur.tag, port, qp, mac, flags, !found, found ? 2'b00 : 2'b01);
        chk("decision", out_bundle(), exp);
        chk_counters();
        hold_and_accept(exp, stall);
    endtask

    task automatic serve_random();
        bit ok;
        wait_lookup(ok);
        if (ok) respond_check($urandom_range(1, 6), 1'($urandom), 16'($urandom), 16'($urandom),
                              {16'($urandom), $urandom}, 3'($urandom), $urandom_range(0, 3));
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        ok = bus.out_valid && (model_q.size() > 0);
        chk("out_seen", 128'(ok), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           ok;
        int           n;
        logic [127:0] exp;
        desc_t        d;
        bus.in_valid = 1'b0; bus.in_dst_ip = '0; bus.in_tag = '0;
        bus.rt_init_done = 1'b0; bus.rt_init_error = 1'b0; bus.out_ready = 1'b0;
        bus.resp_valid = 1'b0; bus.resp_found = 1'b0; bus.resp_out_port = '0; bus.resp_out_qp = '0;
        bus.resp_next_hop_mac = '0; bus.resp_is_direct_host = 1'b0;
        bus.resp_is_broadcast = 1'b0; bus.resp_is_default_route = 1'b0;
        #1;
        do_reset();

        // Descriptors queued before the router is ready, then served in order.
        for (int i = 1; i <= 3; i++) push($urandom, TAG_W'(i));
        repeat (5) tick();
        chk("no_lookup_before_init", 128'(lv_count), 128'(m_issued));
        bus.rt_init_done = 1'b1;
        for (int i = 0; i < 3; i++) serve_random();
        chk("three_lookups", 128'(bus.cnt_lookups), 128'(3));

        // Direct-host hit answered two cycles into the wait.
        push(32'h0A00_0002, 8'h22);
        wait_lookup(ok);
        if (ok) respond_check(2, 1'b1, 16'd2, 16'h0011, 48'h0200_0000_0002, 3'b001, 0);

        // Miss held by downstream backpressure while another descriptor waits.
        push(32'h0A00_0003, 8'h33);
        push(32'h0A00_0004, 8'h34);
        wait_lookup(ok);
        if (ok) respond_check(1, 1'b0, 16'h1234, 16'h5678, 48'hAABB_CCDD_EEFF, 3'b010, 5);
        serve_random();

        // Silent router: timeout, then a stale response is ignored.
        push(32'hC0A8_0001, 8'h44);
        wait_lookup(ok);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 128'(n), 128'(TIMEOUT_CYCLES));
        m_timeout++;
        exp = bundle(8'h44, '0, '0, '0, '0, 1'b1, 2'b10);
        chk("timeout_decision", out_bundle(), exp);
        chk_counters();
        repeat (3) tick();
        bus.resp_valid = 1'b1; bus.resp_found = 1'b0; bus.resp_out_port = 16'hBEEF;
        bus.resp_next_hop_mac = 48'h1111_2222_3333;
        tick();
        bus.resp_valid = 1'b0;
        chk("late_resp_fields", out_bundle(), exp);
        chk_counters();
        hold_and_accept(exp, 0);
        push(32'hC0A8_0002, 8'h45);
        wait_lookup(ok);
        if (ok) respond_check(3, 1'b1, 16'd7, 16'd9, 48'h0000_0000_0707, 3'b110, 1);

        // Randomized bursts.
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push($urandom, TAG_W'($urandom));
            while (model_q.size() > 0) serve_random();
        end

        // FIFO fill while a lookup is outstanding; ninth descriptor refused.
        push(32'h0B00_0000, 8'h60);
        wait_lookup(ok);
        for (int i = 0; i < 8; i++) begin
            chk("in_ready_space", 128'(bus.in_ready), 128'(1));
            push(32'h0B00_0001 + i, TAG_W'(8'h61 + i));
        end
        chk("in_ready_full", 128'(bus.in_ready), 128'(0));
        push(32'h0BFF_FFFF, 8'hFF);
        chk("ninth_refused", 128'(model_q.size()), 128'(8));
        if (ok) respond_check(1, 1'b1, 16'd1, 16'd1, 48'd1, 3'b100, 0);
        for (int i = 0; i < 8; i++) serve_random();
        repeat (10) tick();
        chk("no_extra_lookup", 128'(lv_count), 128'(m_issued));

        // Reset in the middle of a lookup discards queue and in-flight request.
        push(32'h0C00_0001, 8'h70);
        push(32'h0C00_0002, 8'h71);
        wait_lookup(ok);
        tick();
        do_reset();
        repeat (10) tick();
        chk("fifo_empty_after_reset", 128'(lv_count), 128'(m_issued));
        chk("in_ready_after_reset", 128'(bus.in_ready), 128'(1));
        chk("out_valid_after_reset", 128'(bus.out_valid), 128'(0));

        // Router load failure: queued descriptors flushed as drops, no lookups.
        bus.rt_init_done = 1'b0;
        do_reset();
        push(32'h0D00_0001, 8'h51);
        push(32'h0D00_0002, 8'h52);
        bus.rt_init_error = 1'b1;
        bus.rt_init_done  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_out(ok);
            if (ok) begin
                d = model_q.pop_front();
                exp = bundle(d.tag, '0, '0, '0, '0, 1'b1, 2'b11);
                chk("error_decision", out_bundle(), exp);
                hold_and_accept(exp, i);
            end
        end
        bus.rt_init_error = 1'b0;
        push(32'h0D00_0003, 8'h53);
        wait_out(ok);
        if (ok) begin
            d = model_q.pop_front();
            exp = bundle(d.tag, '0, '0, '0, '0, 1'b1, 2'b11);
            chk("error_sticky", out_bundle(), exp);
            hold_and_accept(exp, 0);
        end
        chk_counters();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
